// File: rtl/mdu_sequencer.sv
// Multiply/divide sequencer: computes the HI/LO result at issue, then holds it
// for a fixed number of busy cycles before committing, mimicking an iterative MDU.
module mdu_sequencer #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  input  logic        use_req,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  if (MULT_CYCLES < 1 || DIV_CYCLES < 1) begin : gBadCycles
    $error("mdu_sequencer: MULT_CYCLES and DIV_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV
  } state_e;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

  state_e            state, stateNext;
  logic [CNT_W-1:0]  cnt, cntNext;
  logic [31:0]       pendHi, pendHiNext;
  logic [31:0]       pendLo, pendLoNext;
  logic [31:0]       hiNext, loNext;
  logic              doneNext;

  op_e               opCode;
  logic              isMduOp;

  logic [63:0]       prodSigned, prodUnsigned, product;
  logic              divSigned, negA, negB, divByZero;
  logic [31:0]       magA, magB, divisor, magQ, magR, quot, rem;
  logic [31:0]       divHi, divLo;

  assign opCode  = op_e'(op);
  assign isMduOp = (op >= 3'd1) && (op <= 3'd4);

  // Sign-extended 64x64 multiply keeps the low 64 bits, which equal the signed product.
  assign prodSigned   = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
  assign prodUnsigned = {32'd0, src_a} * {32'd0, src_b};
  assign product      = (opCode == OP_MULT) ? prodSigned : prodUnsigned;

  // Signed divide via magnitudes: quotient sign is the XOR of operand signs,
  // remainder sign follows the dividend. 0x80000000 / -1 wraps naturally to 0x80000000.
  assign divSigned = (opCode == OP_DIV);
  assign negA      = divSigned & src_a[31];
  assign negB      = divSigned & src_b[31];
  assign magA      = negA ? (32'd0 - src_a) : src_a;
  assign magB      = negB ? (32'd0 - src_b) : src_b;
  assign divByZero = (src_b == '0);
  assign divisor   = divByZero ? 32'd1 : magB;
  assign magQ      = magA / divisor;
  assign magR      = magA % divisor;
  assign quot      = (negA ^ negB) ? (32'd0 - magQ) : magQ;
  assign rem       = negA ? (32'd0 - magR) : magR;
  assign divHi     = divByZero ? src_a : rem;
  assign divLo     = divByZero ? '1    : quot;

  assign busy  = (state != IDLE);
  assign stall = use_req & (busy | (start & isMduOp));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      pendHi <= '0;
      pendLo <= '0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      state  <= stateNext;
      cnt    <= cntNext;
      pendHi <= pendHiNext;
      pendLo <= pendLoNext;
      hi     <= hiNext;
      lo     <= loNext;
      done   <= doneNext;
    end
  end

  always_comb begin
    stateNext  = state;
    cntNext    = cnt;
    pendHiNext = pendHi;
    pendLoNext = pendLo;
    hiNext     = hi;
    loNext     = lo;
    doneNext   = 1'b0;

    if (flush) begin
      stateNext  = IDLE;
      cntNext    = '0;
      pendHiNext = '0;
      pendLoNext = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            case (opCode)
              OP_MULT, OP_MULTU: begin
                pendHiNext = product[63:32];
                pendLoNext = product[31:0];
                cntNext    = CNT_W'(MULT_CYCLES - 1);
                stateNext  = MUL;
              end
              OP_DIV, OP_DIVU: begin
                pendHiNext = divHi;
                pendLoNext = divLo;
                cntNext    = CNT_W'(DIV_CYCLES - 1);
                stateNext  = DIV;
              end
              OP_MTHI: hiNext = src_a;
              OP_MTLO: loNext = src_a;
              default: ;
            endcase
          end
        end
        MUL, DIV: begin
          if (cnt == '0) begin
            hiNext    = pendHi;
            loNext    = pendLo;
            doneNext  = 1'b1;
            stateNext = IDLE;
          end else begin
            cntNext = cnt - CNT_W'(1);
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

endmodule

// File: doc/mdu_sequencer.md
MDU_SEQUENCER -- requirements
Module: mdu_sequencer

Interface
REQ-001 SHALL provide parameter MULT_CYCLES, default 5, meaning the busy cycles for MULT/MULTU.
REQ-002 SHALL provide parameter DIV_CYCLES, default 10, meaning the busy cycles for DIV/DIVU.
REQ-003 SHALL use one clock and a synchronous, active-low reset.
REQ-004 SHALL provide port clk, input, 1 bit: rising-edge clock, the only clock.
REQ-005 SHALL provide port reset, input, 1 bit: synchronous, active-low reset (0 = reset).
REQ-006 SHALL provide port start, input, 1 bit: an operation request from the EX stage is valid.
REQ-007 SHALL provide port op, input, 3 bits: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; 7 is treated as NONE.
REQ-008 SHALL provide port src_a, input, 32 bits: rs operand (dividend / multiplicand / MT data).
REQ-009 SHALL provide port src_b, input, 32 bits: rt operand (divisor / multiplier).
REQ-010 SHALL provide port flush, input, 1 bit: cancel any in-flight operation.
REQ-011 SHALL provide port use_req, input, 1 bit: the ID stage holds an MFHI/MFLO/MTHI/MTLO or MDU op.
REQ-012 SHALL provide port busy, output, 1 bit: an operation is in flight.
REQ-013 SHALL provide port stall, output, 1 bit: request to hold PC, IF/ID and ID/EX.
REQ-014 SHALL provide port done, output, 1 bit: one-cycle pulse when HI/LO have just been committed.
REQ-015 SHALL provide port hi, output, 32 bits: architectural HI register.
REQ-016 SHALL provide port lo, output, 32 bits: architectural LO register.

Function
REQ-017 SHALL implement the FSM states IDLE, MUL and DIV; busy = (state != IDLE).
REQ-018 In IDLE, start with op 1/2 SHALL latch the full 64-bit product (signed for 1, unsigned for 2) into pending registers, load the counter with MULT_CYCLES-1, and move to MUL.
REQ-019 In IDLE, start with op 3/4 SHALL latch quotient and remainder (signed for 3, unsigned for 4, both truncated toward zero, remainder sign follows the dividend), load the counter with DIV_CYCLES-1, and move to DIV.
REQ-020 For a multiply, pending hi = product[63:32] and pending lo = product[31:0].
REQ-021 For a divide, pending lo = quotient and pending hi = remainder.
REQ-022 Divide by zero SHALL give pending lo = 32'hFFFFFFFF and pending hi = src_a.
REQ-023 Signed 32'h80000000 / 32'hFFFFFFFF SHALL give lo = 32'h80000000 and hi = 0.
REQ-024 In MUL/DIV the counter SHALL decrement each cycle; on the edge where it equals 0, hi/lo SHALL take the pending values, state SHALL return to IDLE, and done SHALL be 1 for the following cycle only.
REQ-025 If start is accepted at edge E0, busy SHALL be 1 for exactly K cycles (K = MULT_CYCLES or DIV_CYCLES), and new hi/lo SHALL be visible from edge E_K onward, in the same cycle that done=1.
REQ-026 In IDLE, start with op 5 (MTHI) SHALL write src_a to hi, and op 6 (MTLO) SHALL write src_a to lo, at the next edge; these take no busy cycles and produce no done pulse.
REQ-027 start while busy SHALL be ignored, with no state or hi/lo change; the hazard unit is responsible for never issuing it.
REQ-028 stall SHALL equal use_req AND (busy OR (start AND op in 1..4)), and is combinational.
REQ-029 flush SHALL force state to IDLE at the next edge, discard the pending values, leave hi/lo unchanged and keep done=0.
REQ-030 When flush and start occur together, flush SHALL win and the start SHALL be dropped.
REQ-031 When flush coincides with the completion edge, flush SHALL win and no commit SHALL occur.
REQ-032 MULT_CYCLES and DIV_CYCLES SHALL be at least 1, and the counter width SHALL accommodate the larger of the two.

Reset
REQ-033 While reset=0 at a rising edge, hi SHALL be 0, lo 0, busy 0, done 0, state IDLE, counter 0 and pending 0; start and flush are ignored.
REQ-034 Reset asserted mid-operation SHALL abort it with no hi/lo commit; outputs SHALL follow REQ-033 from the next edge.

Verification
REQ-035 MULT with src_a=32'hFFFFFFFE (-2) and src_b=3 -> busy for 5 cycles, then hi=32'hFFFFFFFF, lo=32'hFFFFFFFA, done pulses once.
REQ-036 MULTU with src_a=32'hFFFFFFFF and src_b=2 -> hi=1, lo=32'hFFFFFFFE after 5 busy cycles.
REQ-037 DIV with src_a=-7 and src_b=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF after 10 busy cycles; DIVU with src_b=0 and src_a=9 -> lo=32'hFFFFFFFF, hi=9.
REQ-038 MTLO 32'h1234 while idle -> lo=32'h1234 after 1 edge, busy stays 0; a second DIV start issued during the busy cycles of a running DIV -> ignored, and use_req=1 holds stall=1 until busy falls.
REQ-039 flush at busy cycle 3 of a DIV, and separately reset=0 at cycle 4 of a MULT -> busy=0 at the next edge with hi/lo unchanged (flush) or hi/lo=0 (reset), and no done pulse in either case.
